// File: rtl/axi_burst_master_pkg.sv
// axi_burst_master_pkg: shared AXI constants, FSM states and response ranking.
package axi_burst_master_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

    // Encoding order already matches severity OKAY < SLVERR < DECERR.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 AW/W/B/AR/R channel bundle with master and slave views.
interface axi_burst_master_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_burst_master_beat_counter.sv
// axi_burst_master_beat_counter: saturating burst beat index with last/saturation flags.
module axi_burst_master_beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             clear,
    input  logic             incr,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] cnt,
    output logic             last,
    output logic             sat
);
    assign last = cnt == len;
    assign sat  = &cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETn || clear) cnt <= '0;
        else if (incr && !sat) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst initiator behind a simple request port.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MST_ID = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                done_lenerr,
    axi_burst_master_if.master  axi
);
    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W/8));

    state_t state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0] len_q, cnt;
    logic accept, w_hs, r_hs, b_hs, last, sat, over;
    logic unused;

    assign accept = req_valid && state == IDLE;
    assign w_hs = axi.WVALID && axi.WREADY;
    assign r_hs = axi.RVALID && axi.RREADY;
    assign b_hs = axi.BVALID && axi.BREADY;
    assign unused = ^{axi.BID, axi.RID, cnt, sat};

    axi_burst_master_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .clear(accept),
        .incr(w_hs || r_hs),
        .len(len_q),
        .cnt(cnt),
        .last(last),
        .sat(sat)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = req_valid ? (req_write ? WADDR : RADDR) : IDLE;
            RADDR:   state_n = axi.ARREADY ? RDATA : RADDR;
            RDATA:   state_n = (r_hs && axi.RLAST) ? IDLE : RDATA;
            WADDR:   state_n = axi.AWREADY ? WDATA : WADDR;
            WDATA:   state_n = (w_hs && last) ? WRESP : WDATA;
            WRESP:   state_n = b_hs ? IDLE : WRESP;
            default: state_n = IDLE;
        endcase
    end

    // Beats past len without RLAST leave a sticky mark, since the counter may saturate on len.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            done_resp   <= RESP_OKAY;
            done_lenerr <= 1'b0;
            over        <= 1'b0;
        end else begin
            state    <= state_n;
            rd_valid <= r_hs;
            done     <= b_hs || (r_hs && axi.RLAST);
            if (accept) begin
                addr_q      <= req_addr;
                len_q       <= req_len;
                done_resp   <= RESP_OKAY;
                done_lenerr <= 1'b0;
                over        <= 1'b0;
            end
            if (b_hs) done_resp <= axi.BRESP;
            if (r_hs) begin
                rd_data   <= axi.RDATA;
                done_resp <= resp_max(done_resp, axi.RRESP);
                over      <= over || (last && !axi.RLAST);
                if (axi.RLAST) done_lenerr <= over || !last;
            end
        end
    end

    assign req_ready   = state == IDLE;
    assign axi.AWID    = ID_W'(MST_ID);
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = len_q;
    assign axi.AWSIZE  = AXSIZE;
    assign axi.AWBURST = BURST_INCR;
    assign axi.AWVALID = state == WADDR;
    assign axi.WDATA   = wd_data;
    assign axi.WSTRB   = wd_strb;
    assign axi.WLAST   = last;
    assign axi.WVALID  = state == WDATA && wd_valid;
    assign wd_ready    = state == WDATA && axi.WREADY;
    assign axi.BREADY  = state == WRESP;
    assign axi.ARID    = ID_W'(MST_ID);
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = AXSIZE;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = state == RADDR;
    assign axi.RREADY  = state == RDATA;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: randomized AXI slave plus transaction-level scoreboard for axi_burst_master.
module tb_axi_burst_master;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4;

    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic wd_valid = 1'b0;
    logic [31:0] wd_data = '0;
    logic [3:0] wd_strb = '0;
    logic req_ready, wd_ready, rd_valid, done, done_lenerr;
    logic [31:0] rd_data;
    logic [1:0] done_resp;

    axi_burst_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi();

    axi_burst_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MST_ID(0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .done_resp(done_resp), .done_lenerr(done_lenerr),
        .axi(axi)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave behaviour knobs, set by the stimulus before each request.
    bit cfg_rand = 0, cfg_rresp_rand = 0;
    int cfg_aw_delay = 0, cfg_rlast = 0;
    logic [31:0] cfg_rbase = '0;
    logic [1:0] cfg_rresp = '0, cfg_bresp = '0;
    logic [31:0] wdat[16];
    logic [3:0] wstb[16];
    logic [31:0] rdbuf[32];

    initial begin : slave
        int aw_cnt, r_beat, k;
        bit r_act, b_pend, rhs, bhs, live;
        aw_cnt = 0; r_beat = 0; r_act = 0; b_pend = 0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0; axi.BID = 0;
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0; axi.RLAST = 0; axi.RID = 0;
        forever begin
            @(negedge ACLK);
            live = ARESETn;
            rhs = axi.RVALID && axi.RREADY;
            bhs = axi.BVALID && axi.BREADY;
            if (!live) begin
                aw_cnt = 0; r_act = 0; b_pend = 0; r_beat = 0; rhs = 0; bhs = 0;
            end else begin
                if (axi.AWVALID && axi.AWREADY) aw_cnt = 0;
                else if (axi.AWVALID) aw_cnt++;
                if (axi.ARVALID && axi.ARREADY) begin r_act = 1; r_beat = 0; end
                if (rhs) begin r_beat++; if (axi.RLAST) r_act = 0; end
                if (axi.WVALID && axi.WREADY && axi.WLAST) b_pend = 1;
                if (bhs) b_pend = 0;
            end
            @(posedge ACLK); #1;
            axi.AWREADY = live && aw_cnt >= cfg_aw_delay && (!cfg_rand || $urandom_range(0, 1) == 1);
            axi.ARREADY = live && (!cfg_rand || $urandom_range(0, 1) == 1);
            axi.WREADY  = live && (!cfg_rand || $urandom_range(0, 1) == 1);
            if (!live || !(axi.RVALID && !rhs)) begin
                k = $urandom_range(0, 2);
                axi.RVALID = r_act && (!cfg_rand || $urandom_range(0, 1) == 1);
                axi.RDATA  = 32'(cfg_rbase + 32'(r_beat));
                axi.RRESP  = cfg_rresp_rand ? (k == 0 ? 2'b00 : (k == 1 ? 2'b10 : 2'b11)) : cfg_rresp;
                axi.RLAST  = r_beat == cfg_rlast;
            end
            if (!live || !(axi.BVALID && !bhs)) begin
                axi.BVALID = b_pend && (!cfg_rand || $urandom_range(0, 1) == 1);
                axi.BRESP  = cfg_bresp;
            end
        end
    end

    // Transaction-level reference: what every handshake must carry and what the client must see.
    initial begin : compare
        bit m_write, aw_ok, e_rdv, e_done, e_read, e_le, n_rdv, n_done, n_read, n_le;
        bit p_arv, p_arr, p_awv, p_awr;
        logic [31:0] m_addr, e_rdd, n_rdd, p_ara, p_awa;
        logic [3:0] p_arl, p_awl;
        logic [1:0] acc, e_resp, n_resp;
        int m_len, rb, wb;
        m_write = 0; m_addr = '0; m_len = 0; rb = 0; wb = 0; acc = '0; aw_ok = 0;
        e_rdv = 0; e_done = 0; e_read = 0; e_le = 0; e_rdd = '0; e_resp = '0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_ara = '0; p_awa = '0; p_arl = '0; p_awl = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                aw_ok = 0; e_rdv = 0; e_done = 0; p_arv = 0; p_awv = 0; rb = 0; wb = 0; acc = '0;
                continue;
            end
            chk("rd_valid", rd_valid, e_rdv);
            if (e_rdv) chk("rd_data", rd_data, e_rdd);
            chk("done", done, e_done);
            if (e_done) begin
                chk("done_resp", done_resp, e_resp);
                chk("done_lenerr", done_lenerr, e_read ? e_le : 1'b0);
            end
            if (p_arv && !p_arr) chk("ar_hold", {axi.ARVALID, axi.ARADDR, axi.ARLEN}, {1'b1, p_ara, p_arl});
            if (p_awv && !p_awr) chk("aw_hold", {axi.AWVALID, axi.AWADDR, axi.AWLEN}, {1'b1, p_awa, p_awl});
            chk("wd_hs", wd_valid && wd_ready, axi.WVALID && axi.WREADY);
            if (axi.WVALID) chk("w_after_aw", aw_ok, 1);
            n_rdv = 0; n_done = 0; n_read = 0; n_le = 0; n_rdd = '0; n_resp = '0;
            if (req_valid && req_ready) begin
                m_write = req_write; m_addr = req_addr; m_len = int'(req_len);
                rb = 0; wb = 0; acc = '0; aw_ok = 0;
            end
            if (axi.ARVALID && axi.ARREADY)
                chk("ar_payload", {m_write, axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST},
                    {1'b0, 4'd0, m_addr, 4'(m_len), 3'd2, 2'b01});
            if (axi.AWVALID && axi.AWREADY) begin
                chk("aw_payload", {m_write, axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST},
                    {1'b1, 4'd0, m_addr, 4'(m_len), 3'd2, 2'b01});
                aw_ok = 1;
            end
            if (axi.WVALID && axi.WREADY) begin
                chk("w_beat", {axi.WDATA, axi.WSTRB, axi.WLAST}, {wdat[wb % 16], wstb[wb % 16], wb == m_len});
                wb++;
            end
            if (axi.BVALID && axi.BREADY) begin
                chk("w_beats", wb, m_len + 1);
                n_done = 1; n_resp = axi.BRESP; aw_ok = 0;
            end
            if (axi.RVALID && axi.RREADY) begin
                n_rdv = 1; n_rdd = axi.RDATA;
                acc = (axi.RRESP > acc) ? axi.RRESP : acc;
                if (axi.RLAST) begin
                    n_done = 1; n_resp = acc; n_read = 1; n_le = rb != m_len;
                end
                rb++;
            end
            p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_ara = axi.ARADDR; p_arl = axi.ARLEN;
            p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awa = axi.AWADDR; p_awl = axi.AWLEN;
            e_rdv = n_rdv; e_rdd = n_rdd; e_done = n_done; e_resp = n_resp; e_read = n_read; e_le = n_le;
        end
    end

    task automatic issue(input bit w, input logic [31:0] a, input int l, output int lat);
        lat = 0;
        @(posedge ACLK); #1;
        req_valid = 1; req_write = w; req_addr = a; req_len = 4'(l);
        do begin @(negedge ACLK); lat++; end while (!req_ready && lat < 100);
        chk("req_accept", req_ready, 1);
        @(posedge ACLK); #1;
        req_valid = 0;
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (gaps) repeat ($urandom_range(0, 2)) begin wd_valid = 0; @(posedge ACLK); #1; end
            wd_valid = 1; wd_data = wdat[i]; wd_strb = wstb[i];
            do begin @(negedge ACLK); t++; end while (!wd_ready && t < 200);
            chk("wd_accept", wd_ready, 1);
            @(posedge ACLK); #1;
        end
        wd_valid = 0;
    endtask

    task automatic wait_done(output logic [1:0] r, output bit le, output bit rr, output int n);
        bit got = 0;
        n = 0; r = '0; le = 0; rr = 0;
        for (int t = 0; t < 3000 && !got; t++) begin
            @(negedge ACLK);
            if (rd_valid) begin rdbuf[n % 32] = rd_data; n++; end
            if (done) begin r = done_resp; le = done_lenerr; rr = req_ready; got = 1; end
        end
        chk("done_seen", got, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [1:0] r;
        bit le, rr;
        int n, lat, len, t;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.RREADY, axi.BREADY}, 0);
        chk("rst_outs", {rd_valid, done, done_lenerr, done_resp}, 0);
        @(posedge ACLK); #1;
        ARESETn = 1;

        cfg_rbase = 32'hA0; cfg_rlast = 3; cfg_rresp = 2'b00;
        issue(0, 32'h1000, 3, lat);
        wait_done(r, le, rr, n);
        chk("okrd_count", n, 4);
        for (int i = 0; i < 4; i++) chk("okrd_data", rdbuf[i], 32'hA0 + 32'(i));
        chk("okrd_resp", r, 2'b00);
        chk("okrd_lenerr", le, 0);

        wdat[0] = 32'h11; wdat[1] = 32'h22; wstb[0] = 4'hF; wstb[1] = 4'hF;
        cfg_aw_delay = 3; cfg_bresp = 2'b00;
        issue(1, 32'h2000, 1, lat);
        feed(2, 0);
        wait_done(r, le, rr, n);
        chk("okwr_resp", r, 2'b00);
        chk("okwr_lenerr", le, 0);
        cfg_aw_delay = 0;

        cfg_rbase = 32'h0; cfg_rlast = 0; cfg_rresp = 2'b11;
        issue(0, 32'hDEAD_0000, 3, lat);
        wait_done(r, le, rr, n);
        chk("decrd_count", n, 1);
        chk("decrd_data", rdbuf[0], 32'h0);
        chk("decrd_resp", r, 2'b11);
        chk("decrd_lenerr", le, 1);

        wdat[0] = 32'h5A5A_0001; wstb[0] = 4'h3; cfg_bresp = 2'b11;
        issue(1, 32'hDEAD_0100, 0, lat);
        feed(1, 0);
        wait_done(r, le, rr, n);
        chk("decwr_resp", r, 2'b11);
        chk("decwr_ready_at_done", rr, 1);
        cfg_rbase = 32'h50; cfg_rlast = 3; cfg_rresp = 2'b10;
        issue(0, 32'h3000, 1, lat);
        chk("next_accept_lat", lat, 1);
        wait_done(r, le, rr, n);
        chk("longrd_count", n, 4);
        chk("longrd_last_data", rdbuf[3], 32'h53);
        chk("longrd_resp", r, 2'b10);
        chk("longrd_lenerr", le, 1);

        cfg_rand = 1;
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
                t = $urandom_range(0, 2);
                cfg_bresp = t == 0 ? 2'b00 : (t == 1 ? 2'b10 : 2'b11);
                cfg_aw_delay = $urandom_range(0, 2);
                issue(1, $urandom & 32'hFFFF_FFFC, len, lat);
                feed(len + 1, 1);
                wait_done(r, le, rr, n);
                chk("rndwr_resp", r, cfg_bresp);
            end else begin
                cfg_rbase = $urandom; cfg_rresp_rand = 1;
                cfg_rlast = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : len;
                issue(0, $urandom & 32'hFFFF_FFFC, len, lat);
                wait_done(r, le, rr, n);
                chk("rndrd_count", n, cfg_rlast + 1);
                chk("rndrd_lenerr", le, cfg_rlast != len);
                cfg_rresp_rand = 0;
            end
        end
        cfg_rand = 0; cfg_aw_delay = 0;

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0 + 32'(i); wstb[i] = 4'hF; end
        issue(1, 32'h4000, 3, lat);
        wd_valid = 1; wd_data = wdat[0]; wd_strb = wstb[0];
        t = 0;
        do begin @(negedge ACLK); t++; end while (!wd_ready && t < 200);
        chk("rstw_first_beat", wd_ready, 1);
        @(posedge ACLK); #1;
        wd_data = wdat[1];
        ARESETn = 0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("rstw_valids", {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.RREADY, axi.BREADY}, 0);
        chk("rstw_req_ready", req_ready, 1);
        chk("rstw_done", done, 0);
        @(posedge ACLK); #1;
        ARESETn = 1; wd_valid = 0;

        cfg_rbase = 32'h77; cfg_rlast = 1; cfg_rresp = 2'b00;
        issue(0, 32'h5000, 1, lat);
        wait_done(r, le, rr, n);
        chk("post_rst_count", n, 2);
        chk("post_rst_data", rdbuf[1], 32'h78);
        chk("post_rst_resp", r, 2'b00);

        repeat (3) @(posedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
